fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of instruction_decoder. It owns the PC and issues word-aligned requests to instruction memory over a valid/ready request and in-order response interface. Responses are buffered in a small prefetch FIFO, and the stage drives the IF/ID pipeline register whose id_instruction feeds the decoder. It supports decode-side stall and execute-side redirect (branch/flush).

Parameters:
ADDR_W, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value after reset
FIFO_DEPTH, 2, prefetch entries; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address (= PC)
imem_rsp_valid  in  1  response valid; in order; latency >= 1 cycle
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  flush and load new PC
redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored, forced 0
stall  in  1  decode cannot accept; hold IF/ID
id_valid  out  1  IF/ID holds a valid instruction
id_instruction  out  32  instruction to decoder
id_pc  out  ADDR_W  address of id_instruction
id_pc_plus4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W

Behaviour:
- Reset (async assert, sync deassert handled upstream): pc=RESET_PC; outstanding=0; drop=0; FIFO empty; id_valid=0; id_instruction=32'h0; id_pc=0; id_pc_plus4=0; imem_req_valid=0.
- imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). This is the credit rule: the FIFO can never overflow. imem_req_addr = pc.
- On req handshake: pc <= pc+4 (wraps at 2^ADDR_W), outstanding++.
- On imem_rsp_valid: outstanding--. If drop>0, drop-- and the data is discarded. Otherwise the data and its PC are pushed to the FIFO. The PC comes from a separate response-PC counter advanced on every accepted (non-dropped) response.
- IF/ID update when !stall: if FIFO non-empty, pop the head into id_* and set id_valid=1; else id_valid=0.
- When stall=1, id_* hold and id_valid holds.
- No bypass: minimum latency is request accept at cycle N, response at N+1, FIFO push at N+1, id_valid at N+2.
- A simultaneous FIFO push and pop is legal; fifo_count is unchanged.
- Redirect (priority over stall and over everything else in that cycle):
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}; response-PC counter <= same value.
  - FIFO cleared; id_valid <= 0.
  - drop <= drop + outstanding - (imem_rsp_valid ? 1 : 0).
  - outstanding <= 0, since dropped responses are tracked only in drop.
  - No request issues that cycle; requests resume the next cycle at the new pc.
- Credit with drop>0: issue is allowed when drop + outstanding + fifo_count < FIFO_DEPTH, so stale responses still reserve capacity.
- Back-to-back redirects are legal; each one re-targets and accumulates drop.
- imem_rsp_valid while outstanding+drop == 0 is a protocol error: the response is ignored (assertion in sim).
- rst_n low mid-operation clears all state immediately. Responses that return after reset are covered by the error rule above.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched [31:0] (increments on each IF/ID load with id_valid=1) and perf_bubbles [31:0] (increments each cycle !stall && FIFO empty && !redirect_valid). Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- cpu_pkg holds:
  - INSTR_W=32, ADDR_W, RESET_PC
  - NOP_INSTR constant
  - field-position constants shared with instruction_decoder: cond[31:28], opcode[27:23], Rn[22:19], Rm[18:15], Rd[14:11], imm[10:0]
- Sub-module fetch_fifo: synchronous FIFO holding {pc, instruction}, with push/pop/clear/count and FIFO_DEPTH parameter. fetch_stage instantiates it once.

Test Plan:
- Reset, memory ready, 1-cycle latency, mem[0]=E680100A, mem[4]=E0213000 -> id_valid first high 2 cycles after first handshake. id_pc=0, id_instruction=E680100A, id_pc_plus4=4; next cycle id_pc=4, id_instruction=E0213000.
- imem_req_ready=0 for 5 cycles -> imem_req_addr held at 0x0, pc unchanged, id_valid=0 throughout.
- stall=1 for 3 cycles while id_pc=0x4 -> id_* unchanged. After stall drops, id_pc=0x8 with no instruction lost or duplicated.
- Memory latency 3, two requests in flight (0x8, 0xC), redirect_pc=0x43 -> both stale responses discarded, next request addr=0x40, next id_pc=0x40, drop returns to 0.
- redirect_valid and stall asserted together -> id_valid=0 next cycle, pc=redirect target.
- rst_n pulsed low mid-stream with FIFO full -> all outputs at reset values asynchronously. Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, reset PC and the instruction field
// layout that both fetch_stage and instruction_decoder agree on.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE000_0000;

  // Field positions of an instruction word.
  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 28;
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 23;
  localparam int RN_MSB     = 22;
  localparam int RN_LSB     = 19;
  localparam int RM_MSB     = 18;
  localparam int RM_LSB     = 15;
  localparam int RD_MSB     = 14;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 10;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel and in-order response channel.
interface fetch_stage_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) ();

  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [ADDR_W-1:0]          imem_req_addr;
  logic                       imem_rsp_valid;
  logic [cpu_pkg::INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} entries; synchronous clear drops all
// entries in one cycle.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // NOTE: the storage array has no reset; an entry is only ever read after a
    // push has written it, so resetting pointers and count is sufficient.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO and
// IF/ID register. Optional perf counters under `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                ADDR_W     = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fetch_stage_if.master                imem,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         stall,
    output logic                         id_valid,
    output logic [cpu_pkg::INSTR_W-1:0]  id_instruction,
    output logic [ADDR_W-1:0]            id_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_bubbles,
`endif
    output logic [ADDR_W-1:0]            id_pc_plus4
);

    localparam int INSTR_W = cpu_pkg::INSTR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W   = CNT_W + 2;
    localparam int FIFO_W  = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_head;
    logic [ADDR_W-1:0] head_pc;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              redirect_pc_unused;

    assign redirect_aligned   = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign redirect_pc_unused = ^redirect_pc[1:0];

    // Stale responses still owed to us occupy credit just like live ones.
    assign credit_ok = (SUM_W'(drop) + SUM_W'(outstanding) + SUM_W'(fifo_count))
                       < SUM_W'(FIFO_DEPTH);

    assign imem.imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem.imem_req_addr  = pc;

    assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_accept = imem.imem_rsp_valid && ((outstanding != '0) || (drop != '0));
    assign fifo_push  = rsp_accept && (drop == '0) && !redirect_valid;
    assign fifo_pop   = !redirect_valid && !stall && !fifo_empty;
    assign head_pc    = fifo_head[FIFO_W-1 -: ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            outstanding <= '0;
            drop        <= drop + outstanding - CNT_W'(rsp_accept);
        end else begin
            if (req_fire)  pc     <= pc + ADDR_W'(4);
            if (fifo_push) rsp_pc <= rsp_pc + ADDR_W'(4);
            if (rsp_accept && (drop != '0)) drop <= drop - CNT_W'(1);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(fifo_push);
        end
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (FIFO_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data ({rsp_pc, imem.imem_rsp_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // IF/ID register: payload only changes on a pop, so a bubble keeps the last PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid       <= 1'b0;
            id_instruction <= '0;
            id_pc          <= '0;
            id_pc_plus4    <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_valid <= !fifo_empty;
            if (!fifo_empty) begin
                id_instruction <= fifo_head[INSTR_W-1:0];
                id_pc          <= head_pc;
                id_pc_plus4    <= head_pc + ADDR_W'(4);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fifo_pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (!stall && fifo_empty && !redirect_valid && (perf_bubbles != '1))
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem.imem_rsp_valid && (outstanding == '0) && (drop == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: fixed-latency memory, queue-based reference model
// compared every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam int AW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          stall = 1'b0;
    logic          id_valid;
    logic [31:0]   id_instruction;
    logic [AW-1:0] id_pc;
    logic [AW-1:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(AW)) imem ();

    fetch_stage #(
        .ADDR_W     (AW),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles),
`endif
        .id_pc_plus4    (id_pc_plus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE680_100A;
        if (a == 32'h4) return 32'hE021_3000;
        return 32'h5A00_0000 ^ a;
    endfunction

    // Memory: fixed latency, in order, at most one response per cycle.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    cyc = 0;
    int    mem_lat = 1;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            imem.imem_rsp_valid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = 32'h0;
        end
    end

    // Reference model: architectural view of PC, credits, drop count and FIFO.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t      q[$];
    entry_t      e;
    logic [31:0] m_pc, m_rsp_pc, m_idpc, m_idp4, m_idins;
    logic        m_idv;
    int          m_out, m_drop;
    logic        pred_valid, fire, rsp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = 0; m_rsp_pc = 0; m_out = 0; m_drop = 0; q.delete();
            m_idv = 0; m_idpc = 0; m_idp4 = 0; m_idins = 0;
            pend.delete();
            check("rst req_valid", imem.imem_req_valid, 1'b0);
            check("rst id_valid", id_valid, 1'b0);
        end else begin
            pred_valid = !redirect_valid && (m_drop + m_out + q.size() < DEPTH);
            check("req_valid", imem.imem_req_valid, pred_valid);
            check("req_addr", imem.imem_req_addr, m_pc);
            check("id_valid", id_valid, m_idv);
            check("id_pc", id_pc, m_idpc);
            check("id_pc_plus4", id_pc_plus4, m_idp4);
            check("id_instruction", id_instruction, m_idins);

            if (imem.imem_req_valid && imem.imem_req_ready)
                pend.push_back('{imem.imem_req_addr, cyc + mem_lat});

            fire = pred_valid && imem.imem_req_ready;
            rsp  = imem.imem_rsp_valid && (m_out + m_drop > 0);
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'h3;
                m_rsp_pc = m_pc;
                q.delete();
                m_idv = 0;
                m_drop = m_drop + m_out - (rsp ? 1 : 0);
                m_out = 0;
            end else begin
                if (!stall) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        m_idv = 1; m_idpc = e.pc; m_idp4 = e.pc + 32'd4; m_idins = e.instr;
                    end else begin
                        m_idv = 0;
                    end
                end
                if (fire) begin m_pc = m_pc + 32'd4; m_out++; end
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        m_out--;
                        q.push_back('{m_rsp_pc, imem.imem_rsp_data});
                        m_rsp_pc = m_rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_id(input string name);
        int n = 0;
        tick();
        while (!id_valid && n < 30) begin tick(); n++; end
        if (!id_valid) check({name, " timeout"}, id_valid, 1'b1);
    endtask

    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;

        repeat (3) tick();
        check("reset id_pc", id_pc, 32'h0);
        check("reset id_instruction", id_instruction, 32'h0);
        check("reset id_pc_plus4", id_pc_plus4, 32'h0);
        check("reset req_valid", imem.imem_req_valid, 1'b0);
        rst_n = 1'b1;

        // Memory not ready: PC must not move.
        repeat (5) begin
            tick();
            check("noready addr", imem.imem_req_addr, 32'h0);
            check("noready id_valid", id_valid, 1'b0);
        end
        imem.imem_req_ready = 1'b1;
        #1;
        check("first req_valid", imem.imem_req_valid, 1'b1);

        // First handshake at the next edge; id_valid rises two edges later.
        tick();
        tick();
        check("no bypass", id_valid, 1'b0);
        tick();
        check("first id_valid", id_valid, 1'b1);
        check("first id_pc", id_pc, 32'h0);
        check("first id_instruction", id_instruction, 32'hE680_100A);
        check("first id_pc_plus4", id_pc_plus4, 32'h4);
        tick();
        check("second id_pc", id_pc, 32'h4);
        check("second id_instruction", id_instruction, 32'hE021_3000);

        // Decode stall holds IF/ID.
        stall = 1'b1;
        repeat (3) begin
            tick();
            check("stall id_pc", id_pc, 32'h4);
            check("stall id_valid", id_valid, 1'b1);
        end
        stall = 1'b0;
        tick();
        check("post-stall id_pc", id_pc, 32'h8);
        check("post-stall id_instruction", id_instruction, 32'h5A00_0008);
        tick();
        check("post-stall next id_pc", id_pc, 32'hC);

        // Redirect with two requests in flight at latency 3.
        rst_n = 1'b0;
        repeat (2) tick();
        mem_lat = 3;
        rst_n = 1'b1;
        begin
            int n = 0;
            while (!(imem.imem_req_valid && imem.imem_req_addr == 32'hC) && n < 40) begin
                tick(); n++;
            end
            check("reach 0xC request", imem.imem_req_addr, 32'hC);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        #1;
        check("redirect blocks req", imem.imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redirect new pc", imem.imem_req_addr, 32'h40);
        check("stale credit held", imem.imem_req_valid, 1'b0);
        check("redirect id_valid", id_valid, 1'b0);
        wait_id("redirect fetch");
        check("redirect id_pc", id_pc, 32'h40);
        check("redirect id_instruction", id_instruction, 32'h5A00_0040);

        // Redirect together with stall.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redirect+stall id_valid", id_valid, 1'b0);
        check("redirect+stall pc", imem.imem_req_addr, 32'h100);

        // Stay stalled so the FIFO fills, then reset mid-cycle.
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        check("async rst req_valid", imem.imem_req_valid, 1'b0);
        check("async rst id_valid", id_valid, 1'b0);
        check("async rst id_pc", id_pc, 32'h0);
        check("async rst id_instruction", id_instruction, 32'h0);
        check("async rst id_pc_plus4", id_pc_plus4, 32'h0);
        check("async rst addr", imem.imem_req_addr, 32'h0);
        stall = 1'b0;
        repeat (2) tick();
        mem_lat = 1;
        rst_n = 1'b1;
        wait_id("restart fetch");
        check("restart id_pc", id_pc, 32'h0);
        check("restart id_instruction", id_instruction, 32'hE680_100A);

        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
